// File: rtl/ps_serial.sv
`default_nettype none
// ============================================================================
//  Module   : ps_serial
//  Purpose  : Sequential ASCON substitution layer. Applies the 5-bit S-box to
//             the 64 columns of a 320-bit state, SLICES columns per clock,
//             with a start/busy/done handshake.
//  Options  : PS_ADD_CONST_EN - adds a 4-bit round_i port and folds the ASCON
//             round-constant addition into the capture of word S2.
//  Revision : 1.0 - initial release
// ============================================================================
//  State layout: state[319:256]=S0, [255:192]=S1, [191:128]=S2,
//                [127:64]=S3,  [63:0]=S4   (i.e. {S0,S1,S2,S3,S4}).
//  Column j S-box index = {S0[j],S1[j],S2[j],S3[j],S4[j]}, S0 is the MSB.
// ============================================================================

module ps_serial #(
    parameter int SLICES = 8
) (
    input  logic           clock_i,
    input  logic           resetb_i,
    input  logic           start_i,
`ifdef PS_ADD_CONST_EN
    input  logic [3:0]     round_i,
`endif
    input  logic [319:0]   state_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [319:0]   state_o
);

    // Number of busy cycles per operation and the matching counter width.
    localparam int N  = (SLICES > 0 && SLICES <= 64) ? (64 / SLICES) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // Reject any slice count that does not evenly tile 64 columns.
    generate
        if (!(SLICES == 1 || SLICES == 2 || SLICES == 4 || SLICES == 8 ||
              SLICES == 16 || SLICES == 32 || SLICES == 64)) begin : g_bad_slices
            $error("ps_serial: SLICES must be one of 1,2,4,8,16,32,64");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_t;

    fsm_t            fsm_q;
    logic [CW-1:0]   cnt_q;
    logic [319:0]    work_q;
    logic [319:0]    result_q;
    logic            done_q;

    logic [319:0]    cap_d;
    logic [319:0]    step_d;
    logic [63:0]     words_d [5];
    logic [4:0]      idx_d;
    logic [4:0]      sb_d;

    // ASCON 5-bit S-box.
    function automatic logic [4:0] sbox(input logic [4:0] x);
        logic [4:0] y;
        case (x)
            5'd0:  y = 5'h04;  5'd1:  y = 5'h0b;  5'd2:  y = 5'h1f;  5'd3:  y = 5'h14;
            5'd4:  y = 5'h1a;  5'd5:  y = 5'h15;  5'd6:  y = 5'h09;  5'd7:  y = 5'h02;
            5'd8:  y = 5'h1b;  5'd9:  y = 5'h05;  5'd10: y = 5'h08;  5'd11: y = 5'h12;
            5'd12: y = 5'h1d;  5'd13: y = 5'h03;  5'd14: y = 5'h06;  5'd15: y = 5'h1c;
            5'd16: y = 5'h1e;  5'd17: y = 5'h13;  5'd18: y = 5'h07;  5'd19: y = 5'h0e;
            5'd20: y = 5'h00;  5'd21: y = 5'h0d;  5'd22: y = 5'h11;  5'd23: y = 5'h18;
            5'd24: y = 5'h10;  5'd25: y = 5'h0c;  5'd26: y = 5'h01;  5'd27: y = 5'h19;
            5'd28: y = 5'h16;  5'd29: y = 5'h0a;  5'd30: y = 5'h0f;  default: y = 5'h17;
        endcase
        return y;
    endfunction

    // Rotate a word right by SLICES; after N steps every column is home again.
    function automatic logic [63:0] rotr(input logic [63:0] w);
        return (w >> SLICES) | (w << (64 - SLICES));
    endfunction

    // Captured state, optionally with the round constant folded into S2.
    always_comb begin
        cap_d = state_i;
`ifdef PS_ADD_CONST_EN
        cap_d[191:128] = state_i[191:128] ^ {56'h0, 4'(4'hF - round_i), round_i};
`endif
    end

    // One step: substitute the lowest SLICES columns, then rotate each word so
    // the next unprocessed group lands at bit 0 (columns advance from bit 0 up).
    always_comb begin
        idx_d  = '0;
        sb_d   = '0;
        step_d = '0;
        for (int k = 0; k < 5; k++) begin
            words_d[k] = work_q[64*(4-k) +: 64];
        end
        for (int c = 0; c < SLICES; c++) begin
            idx_d = {words_d[0][c], words_d[1][c], words_d[2][c], words_d[3][c], words_d[4][c]};
            sb_d  = sbox(idx_d);
            for (int k = 0; k < 5; k++) begin
                words_d[k][c] = sb_d[4-k];
            end
        end
        for (int k = 0; k < 5; k++) begin
            step_d[64*(4-k) +: 64] = rotr(words_d[k]);
        end
    end

    // Handshake FSM, column counter, working register and result register.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q    <= ST_IDLE;
            cnt_q    <= '0;
            work_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                ST_IDLE: begin
                    if (start_i) begin
                        work_q <= cap_d;
                        cnt_q  <= '0;
                        fsm_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    work_q <= step_d;
                    if (cnt_q == LAST) begin
                        // Result becomes visible only here, never part-way.
                        result_q <= step_d;
                        done_q   <= 1'b1;
                        cnt_q    <= '0;
                        fsm_q    <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o  = (fsm_q == ST_RUN);
    assign done_o  = done_q;
    assign state_o = result_q;

endmodule

`default_nettype wire
